video_vga_rx: RTL and testbench
===============================

# video_vga_rx

Receive-side VGA timing decoder and frame checker. It samples a VGA-style stream (4:4:4 RGB, active-low hsync/vsync, active flag) on the same clock as the stream source. It recovers per-pixel x/y coordinates, measures the line and frame geometry, and tracks lock with a small state machine. It also accumulates a per-frame pixel checksum, so on-chip self-test and simulation benches can check the video output path without an external monitor.

## Interface
- `MAX_COUNT`, default 1023: saturation value of all 10-bit timing counters. Reaching it is a timeout.
- `clk` input 1: pixel clock, the same clock as the stream source.
- `rst` input 1: reset, asynchronous, active-high.
- `vga_r`, `vga_g`, `vga_b` input 4 each: pixel colour.
- `vga_hsync` input 1: horizontal sync, active low.
- `vga_vsync` input 1: vertical sync, active low.
- `vga_active` input 1: pixel is in the visible area.
- `pixel_rgb` output 12: registered `{r,g,b}` of the current visible pixel.
- `pixel_x`, `pixel_y` output 10 each: coordinates of `pixel_rgb`.
- `pixel_valid` output 1: `pixel_rgb`, `pixel_x` and `pixel_y` are valid.
- `line_start`, `frame_start` output 1 each: one-cycle pulses on hsync / vsync assertion.
- `h_total`, `h_active_len`, `h_sync_len` output 10 each: geometry latched from the last complete line.
- `v_total`, `v_active_len`, `v_sync_len` output 10 each: geometry latched from the last complete frame.
- `frame_sum` output 32: pixel checksum of the last complete frame.
- `frame_sum_valid` output 1: one-cycle pulse when `frame_sum` updates.
- `locked` output 1: geometry has been stable for at least one full frame.
- `timing_error` output 1: one-cycle pulse on a mismatch or a timeout.

## Operation
- **Input stage.** All inputs are registered once (stage S1).
  - `hs = ~vga_hsync_q`, `vs = ~vga_vsync_q`.
  - An assertion edge means the signal was 0 in the previous S1 cycle and is 1 in this one.
- **Horizontal counting.**
  - `hcnt` counts cycles since the last hs edge.
  - On each hs edge, latch `h_total = hcnt + 1` and latch the line's active count into `h_active_len`.
  - `h_sync_len` = number of cycles hs was high, latched on the hs falling edge.
  - After latching, `hcnt` and the active count clear.
- **Pixel coordinates.**
  - `pixel_x` = number of active cycles earlier in the current line.
  - `pixel_y` = number of lines since the last vs edge that contained at least one active cycle.
  - `y` increments on the hs edge only if the closing line had any active cycle.
- **Vertical counting.**
  - `vcnt` counts hs edges since the last vs edge.
  - On each vs edge, latch `v_total = vcnt`, `v_active_len = y`, and `v_sync_len` (hs edges while vs was high, latched on vs fall).
  - After latching, `vcnt` and `y` clear.
- **Simultaneous hs and vs edges.** Close the line first (its line is counted), then close the frame.
- **Checksum.**
  - `sum` accumulates the 12-bit `{r,g,b}` zero-extended, modulo 2^32, on every active cycle.
  - On a vs edge, `frame_sum <= sum` (including a pixel active in that same cycle) and `sum` clears.
  - `frame_sum_valid` pulses only in LOCKED or MEASURE, never for the first partial frame after SEARCH.
- **Lock FSM (states SEARCH, MEASURE, LOCKED).**
  - SEARCH: `locked` = 0. A vs edge moves to MEASURE.
  - MEASURE: `locked` = 0. On the next vs edge, store the six geometry values as reference and go to LOCKED.
  - LOCKED: `locked` = 1.
    - At every vs edge, compare the newly latched six values with the reference.
    - Any difference: pulse `timing_error`, store the new values as reference, go to MEASURE.
  - Timeout, from any state: `hcnt` reaches `MAX_COUNT`, or `vcnt` reaches `MAX_COUNT`.
    - Pulse `timing_error` (once per timeout entry) and go to SEARCH.
    - Counters saturate, they do not wrap.
    - Geometry outputs hold their last values.
- **Reset.**
  - All outputs 0, FSM in SEARCH.
  - Counters, sum and the S1 registers cleared; S1 hsync/vsync reset to 1 (deasserted).
  - Reset mid-frame discards the partial frame.

## Timing
- Input to output latency is 2 cycles: S1 input register, then S2 output register.
  - `pixel_valid`, `pixel_rgb`, `pixel_x`, `pixel_y`, `line_start` and `frame_start` all appear 2 cycles after the corresponding input cycle.
- Geometry outputs, `frame_sum`, `frame_sum_valid`, `locked` and `timing_error` update in the same S2 cycle as the causing `line_start` / `frame_start`.
- `pixel_x` = 0 on the first active cycle of a line, even if `vga_active` drops and resumes within the line (the count continues, no reset).
- There is no back-pressure: one pixel per clock, no handshake.

## Test plan
- **Standard 640x480@60 stream, 3 frames** (800 total, 640 active, 96 hsync; 525 total, 480 active, 2 vsync).
  - After the 2nd vs edge: `locked` = 1.
  - Geometry outputs read 800/640/96 and 525/480/2.
  - `timing_error` never pulses.
- **Solid colour 0xFFF, locked.** `frame_sum` = 0x4AFB5000 (307200 × 4095), with a `frame_sum_valid` pulse per frame.
- **Coordinate ramp, pixel = (x+y)&0xFFF.**
  - At x=639, y=479: `pixel_rgb` = 0x45E and `pixel_x`/`pixel_y` = 639/479.
  - Each value appears exactly 2 cycles after its input.
- **Change h_total to 801 mid-frame while locked.**
  - At the next vs edge: `timing_error` pulses once and `locked` drops to 0.
  - `locked` = 1 again one frame later; `h_total` = 801.
- **Hold hsync deasserted for 2000 cycles.** `timing_error` pulses at `hcnt` = 1023, state goes to SEARCH, and `h_total` holds 800.
- **Assert rst mid-line, release, then feed a valid stream.**
  - All outputs read 0 during reset.
  - No `frame_sum_valid` pulse until the first full frame after MEASURE.

Source files
------------

// File: rtl/video_vga_rx.sv
// Receive-side VGA timing decoder: recovers pixel coordinates, measures
// line/frame geometry, tracks lock and accumulates a per-frame checksum.
module video_vga_rx #(
    parameter int MAX_COUNT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  vga_r,
    input  logic [3:0]  vga_g,
    input  logic [3:0]  vga_b,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic        vga_active,
    output logic [11:0] pixel_rgb,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic        line_start,
    output logic        frame_start,
    output logic [9:0]  h_total,
    output logic [9:0]  h_active_len,
    output logic [9:0]  h_sync_len,
    output logic [9:0]  v_total,
    output logic [9:0]  v_active_len,
    output logic [9:0]  v_sync_len,
    output logic [31:0] frame_sum,
    output logic        frame_sum_valid,
    output logic        locked,
    output logic        timing_error
);
    localparam logic [9:0] MAXC = 10'(MAX_COUNT);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state, state_n;
    logic [3:0]  r_q, g_q, b_q;
    logic        hsync_q, vsync_q, active_q;
    logic        hs_p, vs_p, to_q;
    logic [9:0]  hcnt, acnt, hsc, vcnt, y, vsc;
    logic [31:0] sum;
    logic [59:0] geo_ref;

    logic        hs, vs, hs_rise, hs_fall, vs_rise, vs_fall;
    logic        to_lvl, h_ok, v_ok, mism, ref_ld, fsv;
    logic [9:0]  x_cur, y_line, y_cur, vcnt_line;
    logic [9:0]  h_total_n, h_act_n, h_sync_n;
    logic [9:0]  v_total_n, v_act_n, v_sync_n;
    logic [59:0] geo_n;
    logic [11:0] rgb;
    logic [31:0] sum_frame;

    function automatic logic [9:0] inc(input logic [9:0] v);
        return (v == MAXC) ? v : v + 10'd1;
    endfunction

    assign hs      = ~hsync_q;
    assign vs      = ~vsync_q;
    assign hs_rise = hs & ~hs_p;
    assign hs_fall = ~hs & hs_p;
    assign vs_rise = vs & ~vs_p;
    assign vs_fall = ~vs & vs_p;
    assign rgb     = {r_q, g_q, b_q};
    assign to_lvl  = (hcnt == MAXC) || (vcnt == MAXC);

    always_comb begin
        x_cur     = hs_rise ? 10'd0 : acnt;
        y_line    = (hs_rise && acnt != 10'd0) ? inc(y) : y;
        y_cur     = vs_rise ? 10'd0 : y_line;
        vcnt_line = hs_rise ? inc(vcnt) : vcnt;
        h_ok      = hs_rise && (hcnt != MAXC);
        v_ok      = vs_rise && (vcnt != MAXC);
        h_total_n = h_ok ? hcnt + 10'd1 : h_total;
        // Blank lines keep the last visible line's active length.
        h_act_n   = (h_ok && acnt != 10'd0) ? acnt : h_active_len;
        h_sync_n  = hs_fall ? hsc : h_sync_len;
        v_total_n = v_ok ? vcnt_line : v_total;
        v_act_n   = v_ok ? y_line : v_active_len;
        v_sync_n  = vs_fall ? vsc : v_sync_len;
        geo_n     = {h_total_n, h_act_n, h_sync_n,
                     v_total_n, v_act_n, v_sync_n};
        sum_frame = sum + (active_q ? {20'd0, rgb} : 32'd0);
    end

    always_comb begin
        state_n = state;
        mism    = 1'b0;
        ref_ld  = 1'b0;
        fsv     = 1'b0;
        if (to_lvl) begin
            state_n = SEARCH;
        end else if (vs_rise) begin
            unique case (state)
                SEARCH: state_n = MEASURE;
                MEASURE: begin
                    ref_ld  = 1'b1;
                    fsv     = 1'b1;
                    state_n = LOCKED;
                end
                LOCKED: begin
                    fsv = 1'b1;
                    if (geo_n != geo_ref) begin
                        mism    = 1'b1;
                        ref_ld  = 1'b1;
                        state_n = MEASURE;
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEARCH;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q             <= '0;
            g_q             <= '0;
            b_q             <= '0;
            hsync_q         <= 1'b1;
            vsync_q         <= 1'b1;
            active_q        <= 1'b0;
            hs_p            <= 1'b0;
            vs_p            <= 1'b0;
            to_q            <= 1'b0;
            hcnt            <= '0;
            acnt            <= '0;
            hsc             <= '0;
            vcnt            <= '0;
            y               <= '0;
            vsc             <= '0;
            sum             <= '0;
            geo_ref         <= '0;
            pixel_rgb       <= '0;
            pixel_x         <= '0;
            pixel_y         <= '0;
            pixel_valid     <= 1'b0;
            line_start      <= 1'b0;
            frame_start     <= 1'b0;
            h_total         <= '0;
            h_active_len    <= '0;
            h_sync_len      <= '0;
            v_total         <= '0;
            v_active_len    <= '0;
            v_sync_len      <= '0;
            frame_sum       <= '0;
            frame_sum_valid <= 1'b0;
            locked          <= 1'b0;
            timing_error    <= 1'b0;
        end else begin
            r_q      <= vga_r;
            g_q      <= vga_g;
            b_q      <= vga_b;
            hsync_q  <= vga_hsync;
            vsync_q  <= vga_vsync;
            active_q <= vga_active;
            hs_p     <= hs;
            vs_p     <= vs;
            to_q     <= to_lvl;
            hcnt     <= hs_rise ? 10'd0 : inc(hcnt);
            acnt     <= active_q ? inc(x_cur) : x_cur;
            hsc      <= hs_rise ? 10'd1 : (hs ? inc(hsc) : hsc);
            vcnt     <= vs_rise ? 10'd0 : vcnt_line;
            y        <= y_cur;
            // An hs edge coinciding with the vs edge belongs to the sync.
            vsc      <= vs_rise ? {9'd0, hs_rise}
                                : ((vs && hs_rise) ? inc(vsc) : vsc);
            sum      <= vs_rise ? 32'd0 : sum_frame;
            if (ref_ld) geo_ref <= geo_n;
            pixel_rgb       <= rgb;
            pixel_x         <= x_cur;
            pixel_y         <= y_cur;
            pixel_valid     <= active_q;
            line_start      <= hs_rise;
            frame_start     <= vs_rise;
            h_total         <= h_total_n;
            h_active_len    <= h_act_n;
            h_sync_len      <= h_sync_n;
            v_total         <= v_total_n;
            v_active_len    <= v_act_n;
            v_sync_len      <= v_sync_n;
            frame_sum_valid <= fsv;
            if (fsv) frame_sum <= sum_frame;
            locked          <= (state_n == LOCKED);
            timing_error    <= mism | (to_lvl & ~to_q);
        end
    end
endmodule

// File: tb/tb_video_vga_rx.sv
// Randomized bench for video_vga_rx: a frame generator with a queued
// per-cycle expectation model, plus lock, timeout and reset scenarios.
module tb_video_vga_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
    logic        vga_hsync = 1'b1, vga_vsync = 1'b1, vga_active = 1'b0;
    logic [11:0] pixel_rgb;
    logic [9:0]  pixel_x, pixel_y;
    logic        pixel_valid, line_start, frame_start;
    logic [9:0]  h_total, h_active_len, h_sync_len;
    logic [9:0]  v_total, v_active_len, v_sync_len;
    logic [31:0] frame_sum;
    logic        frame_sum_valid, locked, timing_error;

    video_vga_rx dut (
        .clk(clk), .rst(rst),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_active(vga_active),
        .pixel_rgb(pixel_rgb), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_valid(pixel_valid),
        .line_start(line_start), .frame_start(frame_start),
        .h_total(h_total), .h_active_len(h_active_len),
        .h_sync_len(h_sync_len),
        .v_total(v_total), .v_active_len(v_active_len),
        .v_sync_len(v_sync_len),
        .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid),
        .locked(locked), .timing_error(timing_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          pv, ls, fs, fsv, err, lk, geo, ign;
        logic [11:0] rgb;
        int          x, y, ht, ha, hs, vt, va, vs;
        logic [31:0] sum;
    } rec_t;

    rec_t        q[$];
    int          checks = 0, errors = 0, nerr = 0;
    int          HA, HF, HS, HB, HT, VA, VF, VS, VB, VT;
    int          edges = 0, prev_ht = 0;
    bit          lk = 0, ign = 0, prev_hs = 1, prev_vs = 1;
    logic [31:0] acc = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cmp(input rec_t r);
        check("pixel_valid", 32'(pixel_valid), 32'(r.pv));
        check("line_start", 32'(line_start), 32'(r.ls));
        check("frame_start", 32'(frame_start), 32'(r.fs));
        if (r.pv) begin
            check("pixel_rgb", 32'(pixel_rgb), 32'(r.rgb));
            check("pixel_x", 32'(pixel_x), r.x);
            check("pixel_y", 32'(pixel_y), r.y);
        end
        if (r.ign) begin
            if (timing_error) nerr++;
        end else begin
            check("locked", 32'(locked), 32'(r.lk));
            check("timing_error", 32'(timing_error), 32'(r.err));
        end
        check("frame_sum_valid", 32'(frame_sum_valid), 32'(r.fsv));
        if (r.fsv) check("frame_sum", frame_sum, r.sum);
        if (r.geo) begin
            check("h_total", 32'(h_total), r.ht);
            check("h_active_len", 32'(h_active_len), r.ha);
            check("h_sync_len", 32'(h_sync_len), r.hs);
            check("v_total", 32'(v_total), r.vt);
            check("v_active_len", 32'(v_active_len), r.va);
            check("v_sync_len", 32'(v_sync_len), r.vs);
        end
    endtask

    task automatic drive(input bit hsn, input bit vsn, input bit act,
                         input logic [11:0] rgb, input int x, input int y);
        rec_t r;
        @(posedge clk);
        #1;
        if (q.size() == 2) cmp(q.pop_front());
        vga_hsync  = hsn;
        vga_vsync  = vsn;
        vga_active = act;
        {vga_r, vga_g, vga_b} = rgb;
        r.pv  = act;
        r.rgb = rgb;
        r.x   = x;
        r.y   = y;
        r.ls  = !hsn && prev_hs;
        r.fs  = !vsn && prev_vs;
        r.fsv = 0;
        r.err = 0;
        r.geo = 0;
        r.sum = '0;
        if (act) acc += {20'd0, rgb};
        if (r.fs) begin
            r.sum = acc;
            acc   = '0;
            if (edges > 0) begin
                r.fsv = 1;
                r.geo = 1;
                if (lk && HT != prev_ht) begin
                    r.err = 1;
                    lk    = 0;
                end else begin
                    lk = 1;
                end
            end
            prev_ht = HT;
            edges++;
        end
        r.lk  = lk;
        r.ign = ign;
        r.ht  = HT;
        r.ha  = HA;
        r.hs  = HS;
        r.vt  = VT;
        r.va  = VA;
        r.vs  = VS;
        prev_hs = hsn;
        prev_vs = vsn;
        q.push_back(r);
    endtask

    task automatic cyc(input int l, input int p, input int mode);
        bit          act, hsn, vsn;
        logic [11:0] rgb;
        act = (l < VA) && (p < HA);
        hsn = !((p >= HA + HF) && (p < HA + HF + HS));
        vsn = !((l >= VA + VF) && (l < VA + VF + VS));
        case (mode)
            1:       rgb = 12'hFFF;
            2:       rgb = 12'(p + l);
            default: rgb = 12'($urandom);
        endcase
        drive(hsn, vsn, act, rgb, p, l);
    endtask

    task automatic run_frame(input int mode, input int chg);
        for (int l = 0; l < VT; l++) begin
            if (l == chg) begin
                HB++;
                HT++;
            end
            for (int p = 0; p < HT; p++) cyc(l, p, mode);
        end
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        vga_hsync  = 1'b1;
        vga_vsync  = 1'b1;
        vga_active = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_pixel", {pixel_rgb, pixel_x, pixel_valid}, 32'd0);
        check("rst_pixel_y", 32'(pixel_y), 32'd0);
        check("rst_starts", {30'd0, line_start, frame_start}, 32'd0);
        check("rst_h", {2'd0, h_total, h_active_len, h_sync_len}, 32'd0);
        check("rst_v", {2'd0, v_total, v_active_len, v_sync_len}, 32'd0);
        check("rst_frame_sum", frame_sum, 32'd0);
        check("rst_flags", {29'd0, frame_sum_valid, locked, timing_error},
              32'd0);
        q.delete();
        rst     = 1'b0;
        acc     = '0;
        edges   = 0;
        lk      = 0;
        prev_hs = 1;
        prev_vs = 1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        do_reset(3);
        HA = $urandom_range(8, 20);
        HF = $urandom_range(1, 4);
        HS = $urandom_range(2, 8);
        HB = $urandom_range(1, 4);
        HT = HA + HF + HS + HB;
        VA = $urandom_range(4, 10);
        VF = $urandom_range(1, 3);
        VS = $urandom_range(1, 3);
        VB = $urandom_range(1, 3);
        VT = VA + VF + VS + VB;

        repeat (3) run_frame(0, -1);
        check("lock_after_2", 32'(locked), 32'd1);
        repeat (2) run_frame(2, -1);
        repeat (2) run_frame(1, -1);
        check("solid_sum", frame_sum, 32'(HA * VA * 4095));

        run_frame(0, 2);
        repeat (2) run_frame(0, -1);
        check("relock", 32'(locked), 32'd1);
        check("relock_h_total", 32'(h_total), HT);

        ign   = 1;
        edges = 0;
        lk    = 0;
        nerr  = 0;
        repeat (2000) drive(1'b1, 1'b1, 1'b0, 12'($urandom), 0, 0);
        check("timeout_locked", 32'(locked), 32'd0);
        check("timeout_h_total", 32'(h_total), HT);
        ign = 0;
        repeat (3) run_frame(0, -1);
        check("timeout_pulses", nerr, 32'd1);
        check("timeout_relock", 32'(locked), 32'd1);

        for (int l = 0; l < 3; l++)
            for (int p = 0; p < HT; p++) cyc(l, p, 0);
        for (int p = 0; p < 7; p++) cyc(3, p, 0);
        do_reset(4);
        repeat (3) run_frame(0, -1);
        check("final_locked", 32'(locked), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
